// File: rtl/video_stream_formatter.sv
// Raster-to-stream formatter: tags SOF/EOL, buffers pixels in a show-ahead FIFO, measures line/frame size.
// Define VSF_STATS_EN to build the line_len / frame_lines measurement counters (tied to 0 otherwise).
module video_stream_formatter #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int N          = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_frame,
    input  logic              pix_en,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              ovf,
    output logic [N-1:0]      line_len,
    output logic [N-1:0]      frame_lines
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int WORD_W = DATA_W + 2;

    logic                sync_q, sync_qq, en_q, en_qq;
    logic                sync_rise, en_fall;
    logic                synced, sof_arm, drop_line;
    logic                hold_vld, hold_sof;
    logic [DATA_W-1:0]   hold_data;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                empty, full, capture, push_try, drop, push, pop;

    assign sync_rise = sync_q & ~sync_qq;
    assign en_fall   = en_qq & ~en_q;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    // Stream handshake: a word transfers when m_valid && m_ready; while m_valid=1 the word is held until taken.
    assign pop      = m_valid & m_ready;
    assign capture  = pix_en & synced & ~drop_line;
    assign push_try = hold_vld & ~drop_line;
    assign drop     = push_try & full & ~pop;
    assign push     = push_try & ~drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 1'b0;
            sync_qq   <= 1'b0;
            en_q      <= 1'b0;
            en_qq     <= 1'b0;
            synced    <= 1'b0;
            sof_arm   <= 1'b0;
            drop_line <= 1'b0;
            ovf       <= 1'b0;
            hold_vld  <= 1'b0;
            hold_sof  <= 1'b0;
            hold_data <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            sync_q  <= sync_frame;
            sync_qq <= sync_q;
            en_q    <= pix_en;
            en_qq   <= en_q;
            if (sync_rise) begin
                synced  <= 1'b1;
                sof_arm <= 1'b1;
            end else if (capture) begin
                sof_arm <= 1'b0;
            end
            hold_vld <= capture;
            if (capture) begin
                hold_sof  <= sof_arm;
                hold_data <= pix_data;
            end
            // A failed push abandons the rest of the line so no EOL-less fragment mixes with the next one.
            if (drop) begin
                ovf       <= 1'b1;
                drop_line <= 1'b1;
            end else if (en_fall) begin
                drop_line <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // EOL is known one cycle after capture: the line ends if pix_en has dropped by push time.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {hold_sof, ~pix_en, hold_data};
    end

    assign m_valid = ~empty;
    assign {m_sof, m_eol, m_data} = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

`ifdef VSF_STATS_EN
    logic [N-1:0] pix_cnt, line_cnt, line_cnt_inc, line_len_r, frame_lines_r;

    // A line ending in the same cycle as a frame edge is counted into that frame.
    assign line_cnt_inc = (en_fall && line_cnt != '1) ? line_cnt + 1'b1 : line_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt       <= '0;
            line_cnt      <= '0;
            line_len_r    <= '0;
            frame_lines_r <= '0;
        end else begin
            if (en_fall) begin
                line_len_r <= pix_cnt;
                pix_cnt    <= '0;
            end else if (en_q && pix_cnt != '1) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (sync_rise) begin
                frame_lines_r <= line_cnt_inc;
                line_cnt      <= '0;
            end else begin
                line_cnt <= line_cnt_inc;
            end
        end
    end

    assign line_len    = line_len_r;
    assign frame_lines = frame_lines_r;
`else
    assign line_len    = '0;
    assign frame_lines = '0;
`endif

endmodule

// File: tb/tb_video_stream_formatter.sv
// Self-checking bench for video_stream_formatter: directed scenarios plus randomized frames against a queue model.
// Expected statistics follow the VSF_STATS_EN build setting.
module tb_video_stream_formatter;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int N      = 12;
    localparam int MAXC   = (1 << N) - 1;
`ifdef VSF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sync_frame = 1'b0;
    logic              pix_en = 1'b0;
    logic [DATA_W-1:0] pix_data = '0;
    logic              m_ready = 1'b0;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_sof;
    logic              m_eol;
    logic              ovf;
    logic [N-1:0]      line_len;
    logic [N-1:0]      frame_lines;

    video_stream_formatter #(.DATA_W(DATA_W), .DEPTH_LOG2(4), .N(N)) dut (
        .clk(clk), .reset(reset), .sync_frame(sync_frame), .pix_en(pix_en),
        .pix_data(pix_data), .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .ovf(ovf), .line_len(line_len), .frame_lines(frame_lines)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / model state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W+1:0] exp_q[$];     // {sof, eol, data} words expected at the output, in order
    bit                md_synced, md_armed, md_dropping, md_pend_vld, md_pend_sof, md_ovf;
    bit                prev_en, prev_sync;
    logic [DATA_W-1:0] md_pend_data;
    int                run_len, line_count, exp_line_len, exp_frame_lines;
    int                ev_at[$];
    bit                ev_frame[$];
    int                ev_val[$];

    int n_words, n_sof, n_eol, first_valid_cyc, t_first_en;
    int ready_mode = 0;
    bit ready_fixed = 1'b1;
    int ready_pct = 70;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        md_synced = 0; md_armed = 0; md_dropping = 0; md_pend_vld = 0; md_pend_sof = 0;
        md_ovf = 0; prev_en = 0; prev_sync = 0; md_pend_data = '0;
        run_len = 0; line_count = 0; exp_line_len = 0; exp_frame_lines = 0;
        ev_at.delete(); ev_frame.delete(); ev_val.delete();
    endtask

    task automatic sched(input int at, input bit is_frame, input int val);
        ev_at.push_back(at);
        ev_frame.push_back(is_frame);
        ev_val.push_back(val);
    endtask

    // Advances the model by one cycle using the inputs currently applied.
    // Sync pulses and line ends take effect at once here; stimulus keeps >=3 idle cycles around them.
    task automatic model_step();
        bit                pop, cap, rise, fall, old_vld, old_sof;
        logic [DATA_W-1:0] old_data;
        pop = (exp_q.size() > 0) && m_ready;
        if (pop) void'(exp_q.pop_front());
        old_vld  = md_pend_vld;
        old_sof  = md_pend_sof;
        old_data = md_pend_data;
        cap = pix_en && md_synced && !md_dropping;
        if (old_vld && !md_dropping) begin
            if (exp_q.size() == DEPTH) begin
                md_ovf      = 1;
                md_dropping = 1;
            end else begin
                exp_q.push_back({old_sof, !pix_en, old_data});
            end
        end
        md_pend_vld = cap;
        if (cap) begin
            md_pend_sof  = md_armed;
            md_pend_data = pix_data;
            md_armed     = 0;
        end
        fall = prev_en && !pix_en;
        rise = sync_frame && !prev_sync;
        if (fall) begin
            md_dropping = 0;
            if (line_count < MAXC) line_count++;
            sched(cyc + 2, 1'b0, run_len);
            run_len = 0;
        end else if (pix_en && run_len < MAXC) begin
            run_len++;
        end
        if (rise) begin
            md_synced = 1;
            md_armed  = 1;
            sched(cyc + 2, 1'b1, line_count);
            line_count = 0;
        end
        prev_en   = pix_en;
        prev_sync = sync_frame;
    endtask

    // ---------------- monitor: compare DUT against model every cycle ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_valid", 32'(m_valid), 0);
            check("rst_data", 32'(m_data), 0);
            check("rst_sof", 32'(m_sof), 0);
            check("rst_eol", 32'(m_eol), 0);
            check("rst_ovf", 32'(ovf), 0);
            check("rst_line_len", 32'(line_len), 0);
            check("rst_frame_lines", 32'(frame_lines), 0);
            model_clear();
        end else begin
            while (ev_at.size() > 0 && ev_at[0] <= cyc) begin
                if (ev_frame[0]) exp_frame_lines = ev_val[0];
                else             exp_line_len    = ev_val[0];
                void'(ev_at.pop_front());
                void'(ev_frame.pop_front());
                void'(ev_val.pop_front());
            end
            check("valid", 32'(m_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("data", 32'(m_data), 32'(exp_q[0][DATA_W-1:0]));
                check("sof", 32'(m_sof), 32'(exp_q[0][DATA_W+1]));
                check("eol", 32'(m_eol), 32'(exp_q[0][DATA_W]));
            end
            check("ovf", 32'(ovf), 32'(md_ovf));
            check("line_len", 32'(line_len), STATS ? exp_line_len : 0);
            check("frame_lines", 32'(frame_lines), STATS ? exp_frame_lines : 0);
            if (m_valid && m_ready) begin
                n_words++;
                if (m_sof) n_sof++;
                if (m_eol) n_eol++;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            model_step();
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = ready_fixed;
                1:       m_ready = ~m_ready;
                default: m_ready = ($urandom_range(0, 99) < ready_pct);
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input logic en, input logic [DATA_W-1:0] d);
        @(posedge clk);
        #1;
        sync_frame = s;
        pix_en     = en;
        pix_data   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, DATA_W'($urandom));
    endtask

    task automatic sync_pulse();
        drive(1'b1, 1'b0, DATA_W'($urandom));
    endtask

    task automatic line(input int len, input bit seq, input bit mark);
        for (int i = 0; i < len; i++) begin
            drive(1'b0, 1'b1, seq ? DATA_W'(i) : DATA_W'($urandom));
            if (mark && i == 0) t_first_en = cyc;
        end
    endtask

    task automatic clear_counts();
        n_words = 0; n_sof = 0; n_eol = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        model_clear();
        clear_counts();
        first_valid_cyc = 0;
        t_first_en = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // No frame sync yet: everything is discarded.
        ready_fixed = 1'b1;
        repeat (20) drive(1'b0, 1'b1, DATA_W'($urandom));
        idle(4);
        check("s1_words", 32'(n_words), 0);
        check("s1_ovf", 32'(ovf), 0);

        // Three 8-pixel lines; the closing sync lands on the last line's falling edge.
        sync_pulse();
        idle(3);
        clear_counts();
        first_valid_cyc = -1;
        for (int l = 0; l < 3; l++) begin
            line(8, 1'b1, l == 0);
            if (l < 2) idle(4);
        end
        sync_pulse();
        idle(5);
        check("s2_words", 32'(n_words), 24);
        check("s2_sof", 32'(n_sof), 1);
        check("s2_eol", 32'(n_eol), 3);
        check("s2_latency", 32'(first_valid_cyc), 32'(t_first_en + 2));
        check("s2_line_len", 32'(line_len), STATS ? 8 : 0);
        check("s2_frame_lines", 32'(frame_lines), STATS ? 3 : 0);

        // Ready toggling every cycle on a 10-pixel line.
        clear_counts();
        ready_mode = 1;
        line(10, 1'b1, 1'b0);
        idle(25);
        ready_mode = 0;
        idle(2);
        check("s4_words", 32'(n_words), 10);
        check("s4_eol", 32'(n_eol), 1);
        check("s4_ovf", 32'(ovf), 0);

        // Stalled 40-pixel line overflows the FIFO; the next line must come through intact.
        ready_fixed = 1'b0;
        sync_pulse();
        idle(3);
        clear_counts();
        line(40, 1'b1, 1'b0);
        idle(4);
        check("s3_held_words", 32'(n_words), 0);
        check("s3_valid", 32'(m_valid), 1);
        check("s3_ovf", 32'(ovf), 1);
        check("s3_line_len", 32'(line_len), STATS ? 40 : 0);
        ready_fixed = 1'b1;
        idle(24);
        check("s3_drained", 32'(n_words), 16);
        check("s3_no_eol", 32'(n_eol), 0);
        clear_counts();
        line(8, 1'b1, 1'b0);
        idle(6);
        check("s3_next_words", 32'(n_words), 8);
        check("s3_next_eol", 32'(n_eol), 1);
        check("s3_next_len", 32'(line_len), STATS ? 8 : 0);

        // One-cycle reset mid-line with 5 words buffered.
        ready_fixed = 1'b0;
        sync_pulse();
        idle(3);
        line(6, 1'b1, 1'b0);
        drive(1'b0, 1'b1, DATA_W'(6));
        check("s5_pre_valid", 32'(m_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        check("s5_async_valid", 32'(m_valid), 0);
        check("s5_async_data", 32'(m_data), 0);
        check("s5_async_sof", 32'(m_sof), 0);
        check("s5_async_ovf", 32'(ovf), 0);
        clear_counts();
        drive(1'b0, 1'b1, DATA_W'(7));
        reset = 1'b1;
        drive(1'b0, 1'b1, DATA_W'(8));
        idle(6);
        ready_fixed = 1'b1;
        idle(5);
        check("s5_words_after", 32'(n_words), 0);
        check("s5_valid_after", 32'(m_valid), 0);
        check("s5_line_len", 32'(line_len), STATS ? 2 : 0);

        // Randomized frames with random backpressure, some heavy enough to overflow.
        for (int f = 0; f < 6; f++) begin
            ready_mode = 2;
            ready_pct  = (f % 2 == 1) ? 30 : 75;
            sync_pulse();
            idle(3);
            for (int l = 0; l < $urandom_range(1, 4); l++) begin
                line($urandom_range(1, 12), 1'b0, 1'b0);
                idle($urandom_range(3, 6));
            end
        end
        ready_mode  = 0;
        ready_fixed = 1'b1;
        idle(40);
        sync_pulse();
        idle(4);
        check("s6_empty", 32'(m_valid), 0);
        check("s6_frame_lines", 32'(frame_lines), STATS ? exp_frame_lines : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
